// File: rtl/aes_byte_loader.sv
// Byte-serial loader for the AES-128 decrypt core: assembles 16-byte key and
// ciphertext frames, commits them atomically and freezes the buses for a hold window.
module aes_byte_loader #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_key,
  output logic [15:0][7:0] key_out,
  output logic [15:0][7:0] state_out,
  output logic             key_valid,
  output logic             blk_valid,
  output logic [7:0]       blk_count,
  output logic             err,
  output logic             busy
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_KEY  = 2'd1,
    LOAD_DATA = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t           state;
  logic [15:0][7:0] shadow;
  logic [3:0]       byte_cnt;
  logic [7:0]       hold_cnt;
  logic             xfer;

  // The last byte of a frame is merged here so the bus updates on the same
  // edge as the 16th transfer rather than one cycle later.
  function automatic logic [15:0][7:0] commit_frame(input logic [15:0][7:0] sh,
                                                     input logic [7:0]       last);
    logic [15:0][7:0] f;
    f    = sh;
    f[0] = last;
    return f;
  endfunction

  assign in_ready = (state != HOLD);
  assign busy     = (state != IDLE);
  assign xfer     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      byte_cnt  <= '0;
      hold_cnt  <= '0;
      key_out   <= '0;
      state_out <= '0;
      key_valid <= 1'b0;
      blk_valid <= 1'b0;
      blk_count <= '0;
      err       <= 1'b0;
    end else begin
      blk_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (in_is_key) begin
              shadow[15] <= in_byte;
              byte_cnt   <= 4'd1;
              state      <= LOAD_KEY;
            end else if (key_valid) begin
              shadow[15] <= in_byte;
              byte_cnt   <= 4'd1;
              state      <= LOAD_DATA;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD_KEY, LOAD_DATA: begin
          if (xfer) begin
            shadow[4'd15 - byte_cnt] <= in_byte;
            byte_cnt                 <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) begin
              if (state == LOAD_KEY) begin
                key_out   <= commit_frame(shadow, in_byte);
                key_valid <= 1'b1;
                state     <= IDLE;
              end else begin
                state_out <= commit_frame(shadow, in_byte);
                blk_valid <= 1'b1;
                blk_count <= blk_count + 8'd1;
                hold_cnt  <= HOLD_LOAD;
                state     <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          // Counter reads HOLD_LOAD on the first held cycle, so leaving at 1
          // gives exactly HOLD_CYCLES cycles with in_ready low.
          hold_cnt <= hold_cnt - 8'd1;
          if (hold_cnt == 8'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
